// File: rtl/puf_response_collector.sv
// Arbiter PUF response collector.
// Sweeps consecutive challenges and launches an arm/race pair for each evaluation.
// Each challenge is evaluated N_VOTE times and the results are majority-voted.
// The voted bits are shifted into an N_BITS signature, which is offered on a
// valid/ready handshake.
// Any challenge whose evaluations were not unanimous is counted as unstable.
module puf_response_collector #(
  parameter int CH_W   = 8,
  parameter int N_BITS = 32,
  parameter int N_VOTE = 5,
  parameter int SETTLE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CH_W-1:0]   seed_ch,
  input  logic              resp_in,
  output logic [CH_W-1:0]   ch_out,
  output logic              launch,
  output logic              busy,
  output logic [N_BITS-1:0] sig,
  output logic              sig_valid,
  input  logic              sig_ready,
  output logic [7:0]        unstable_cnt
);

  localparam int VW = $clog2(N_VOTE + 1);
  localparam int PW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [VW-1:0] VOTE_ALL  = VW'(N_VOTE);
  localparam logic [VW-1:0] VOTE_HALF = VW'(N_VOTE / 2);
  localparam logic [VW-1:0] VOTE_ONE  = VW'(1);
  localparam logic [PW-1:0] PH_LAST   = PW'(SETTLE - 1);
  localparam logic [PW-1:0] PH_ONE    = PW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(N_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [CH_W-1:0] CH_ONE  = CH_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    RACE   = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [VW-1:0]     vote_q, vote_d;
  logic [VW-1:0]     ones_q, ones_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [N_BITS-1:0] sig_q, sig_d;
  logic [7:0]        unst_q, unst_d;
  logic              vld_q, vld_d;
  logic              sync1_q, sync2_q;

  // The vote is strictly more than half of the evaluations (N_VOTE is odd, so there is no tie).
  function automatic logic majority(input logic [VW-1:0] ones);
    return (ones > VOTE_HALF);
  endfunction

  // Increments the counter and holds it at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Shifts a new bit into the LSB, so the first voted bit ends up in the MSB.
  function automatic logic [N_BITS-1:0] shift_in(input logic [N_BITS-1:0] s, input logic b);
    logic [N_BITS:0] t;
    t = {s, b};
    return t[N_BITS-1:0];
  endfunction

  // Two-flop synchroniser for the asynchronous arbiter response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= resp_in;
      sync2_q <= sync1_q;
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      vote_q  <= '0;
      ones_q  <= '0;
      bit_q   <= '0;
      ch_q    <= '0;
      sig_q   <= '0;
      unst_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      vote_q  <= vote_d;
      ones_q  <= ones_d;
      bit_q   <= bit_d;
      ch_q    <= ch_d;
      sig_q   <= sig_d;
      unst_q  <= unst_d;
      vld_q   <= vld_d;
    end
  end

  // Next-state logic: arm/race sequencing, vote accumulation, commit, and handshake
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    vote_d  = vote_q;
    ones_d  = ones_q;
    bit_d   = bit_q;
    ch_d    = ch_q;
    sig_d   = sig_q;
    unst_d  = unst_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ch_d    = seed_ch;
          sig_d   = '0;
          unst_d  = '0;
          vote_d  = '0;
          ones_d  = '0;
          bit_d   = '0;
          phase_d = '0;
          vld_d   = 1'b0;
          state_d = ARM;
        end
      end
      ARM: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          state_d = RACE;
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end
      RACE: begin
        if (phase_q == PH_LAST) begin
          // The last race cycle gives the arbiter and the synchroniser the longest time to settle.
          phase_d = '0;
          ones_d  = ones_q + VW'(sync2_q);
          vote_d  = vote_q + VOTE_ONE;
          state_d = (vote_d < VOTE_ALL) ? ARM : COMMIT;
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end
      COMMIT: begin
        sig_d = shift_in(sig_q, majority(ones_q));
        if ((ones_q != '0) && (ones_q != VOTE_ALL)) begin
          unst_d = sat_inc(unst_q);
        end
        ch_d   = ch_q + CH_ONE;
        ones_d = '0;
        vote_d = '0;
        if (bit_q == BIT_LAST) begin
          state_d = DONE;
        end else begin
          bit_d   = bit_q + BIT_ONE;
          state_d = ARM;
        end
      end
      DONE: begin
        // The first DONE cycle raises valid; a ready seen before valid is high is ignored.
        if (vld_q && sig_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end else begin
          vld_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ch_out       = ch_q;
  assign launch       = (state_q == RACE);
  assign busy         = (state_q != IDLE);
  assign sig          = sig_q;
  assign sig_valid    = vld_q;
  assign unstable_cnt = unst_q;

endmodule
